mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose parameter READ_LAT, default 2, meaning memory read latency in cycles from address presented to mem_rdata valid (legal range 1..8).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous and active-low (asserted when 0, sampled on rising clk edge).
REQ-004 if_req  input  1  instruction-fetch read request, held until if_ack.
REQ-005 if_addr  input  32  fetch address, stable while if_req high.
REQ-006 if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 if_rdata  output  32  fetched word, registered.
REQ-008 ls_req  input  1  load/store request, held until ls_ack.
REQ-009 ls_we  input  1  1 = store, 0 = load; stable while ls_req high.
REQ-010 ls_addr  input  32  load/store address.
REQ-011 ls_wdata  input  32  store data.
REQ-012 ls_ack  output  1  one-cycle load/store completion pulse.
REQ-013 ls_rdata  output  32  loaded word, registered.
REQ-014 mem_addr  output  32  address to single-port memory.
REQ-015 mem_wdata  output  32  write data to memory.
REQ-016 mem_wr  output  1  memory write strobe (1 = write, 0 = read).
REQ-017 mem_rdata  input  32  memory read data.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 grant_ls  output  1  owner of current/last transaction (1 = LS, 0 = IF).
REQ-020 estado  output  2  current state code: IDLE=0, ACCESS=1, RESP=2.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, RESP; RESP always returns to IDLE.
REQ-022 In IDLE with no request, state SHALL remain IDLE; mem_wr = 0.
REQ-023 In IDLE with exactly one request, that requester SHALL be granted at that edge.
REQ-024 In IDLE with both requests, grant SHALL go to the requester not granted last (round-robin via last_grant register).
REQ-025 On grant, addr, we (0 for IF) and wdata SHALL be latched; grant_ls updated; state -> ACCESS; access counter cleared.
REQ-026 mem_addr and mem_wdata SHALL be driven from latched registers and stay stable through ACCESS and RESP.
REQ-027 Read ACCESS SHALL last exactly READ_LAT cycles; mem_rdata SHALL be captured into the owner's rdata register on the last ACCESS edge; state -> RESP.
REQ-028 Write ACCESS SHALL last exactly 1 cycle with mem_wr = 1; mem_wr SHALL be 0 in every other cycle.
REQ-029 In RESP, owner's ack SHALL be 1 for exactly one cycle; the other ack SHALL be 0.
REQ-030 Latency: request sampled in IDLE at edge T -> ack high in cycle T+READ_LAT+1 (read) or T+2 (write).
REQ-031 Requester SHALL drop req in the cycle after ack; req still high in IDLE is a new request.
REQ-032 Request deasserted mid-transaction SHALL NOT abort it; ack still issued.
REQ-033 Address/data changes on the non-owner port during a transaction SHALL have no effect.
REQ-034 if_rdata/ls_rdata SHALL hold last read value until the next read on that port; stores SHALL NOT alter ls_rdata.
REQ-035 Counter SHALL be wide enough for READ_LAT = 8 with no wrap.

Reset
REQ-036 With reset = 0 at an edge: state IDLE, if_ack = ls_ack = 0, mem_wr = 0, busy = 0, mem_addr = mem_wdata = 0, if_rdata = ls_rdata = 0, grant_ls = 0, last_grant = LS (IF wins first tie), counter 0.
REQ-037 Reset mid-transaction SHALL abort it with no ack and no further mem_wr; behaviour after release SHALL equal power-on.

Verification
REQ-038 READ_LAT=2; if_req, if_addr=0x10, mem word 0x10=0xDEADBEEF -> if_ack one cycle, 3 cycles after grant edge, if_rdata=0xDEADBEEF, mem_wr never 1.
REQ-039 ls_req store, ls_addr=0x40, ls_wdata=0x12345678 -> mem_wr=1 exactly one cycle with mem_addr=0x40, mem_wdata=0x12345678; ls_ack next cycle; ls_rdata unchanged.
REQ-040 Both requests held continuously after reset -> grants IF, LS, IF, LS; no cycle with both acks high.
REQ-041 Load granted, ls_req dropped and if_addr toggled during ACCESS -> load completes, ls_ack pulses, mem_addr constant.
REQ-042 reset=0 during write ACCESS -> next cycle mem_wr=0, busy=0, no ack; subsequent fetch completes normally.
REQ-043 READ_LAT=1 and READ_LAT=8 reads -> ack at grant edge +2 and +9 respectively, correct data.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter that shares one single-port memory between an
// instruction-fetch port (read only) and a load/store port. Each transaction
// walks IDLE -> ACCESS -> RESP -> IDLE. Reads hold ACCESS for READ_LAT cycles.
// Writes hold ACCESS for one cycle with the write strobe high.
// All outputs come straight from registers.
module mem_arbiter #(
    parameter int READ_LAT = 2  // memory read latency in cycles, 1..8
) (
    input  logic        clk,
    input  logic        reset,      // synchronous, active-low

    // instruction-fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    // load/store port
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,

    // single-port memory
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,

    // status
    output logic        busy,
    output logic        grant_ls,
    output logic [1:0]  estado
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Four bits count up to 15. The longest read compares against 7, so the
    // counter never wraps.
    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LAT - 1);

    state_t             r_state;
    logic               r_last_grant;  // 1 = load/store won the last arbitration
    logic               r_grant_ls;    // owner of the current/last transaction
    logic [CNT_W-1:0]   r_cnt;         // ACCESS cycles elapsed for a read
    logic               r_we;          // latched direction of the transaction
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_mem_wr;
    logic               r_if_ack;
    logic               r_ls_ack;
    logic [31:0]        r_if_rdata;
    logic [31:0]        r_ls_rdata;

    logic               w_pick_ls;

    // Arbitration: a lone request wins. On a tie, the port that lost last time wins.
    always_comb begin
        // NOTE: the default comes first, so every path assigns w_pick_ls and no latch is inferred.
        w_pick_ls = 1'b0;
        if (ls_req && (!if_req || !r_last_grant)) begin
            w_pick_ls = 1'b1;
        end
    end

    // Transaction FSM, including the latched request and the registered outputs.
    // NOTE: every register here uses <=, so all updates see the pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;      // load/store counts as last, so fetch wins the first tie
            r_grant_ls   <= 1'b0;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_wr     <= 1'b0;
            r_if_ack     <= 1'b0;
            r_ls_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
        end else begin
            // Acks and the write strobe are pulses. They are raised only by the transitions below.
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            r_mem_wr <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (if_req || ls_req) begin
                        r_grant_ls   <= w_pick_ls;
                        r_last_grant <= w_pick_ls;
                        r_addr       <= w_pick_ls ? ls_addr  : if_addr;
                        r_wdata      <= w_pick_ls ? ls_wdata : 32'd0;
                        r_we         <= w_pick_ls & ls_we;
                        r_mem_wr     <= w_pick_ls & ls_we;
                        r_cnt        <= '0;
                        r_state      <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (r_we || (r_cnt == LAST_CNT)) begin
                        // Last ACCESS edge: a read captures data for its owner only.
                        if (!r_we) begin
                            if (r_grant_ls) begin
                                r_ls_rdata <= mem_rdata;
                            end else begin
                                r_if_rdata <= mem_rdata;
                            end
                        end
                        r_if_ack <= ~r_grant_ls;
                        r_ls_ack <= r_grant_ls;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    // The requester drops req while the FSM passes through IDLE,
                    // so RESP returns without sampling requests.
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_ack    = r_if_ack;
    assign if_rdata  = r_if_rdata;
    assign ls_ack    = r_ls_ack;
    assign ls_rdata  = r_ls_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wr    = r_mem_wr;
    assign busy      = (r_state != ST_IDLE);
    assign grant_ls  = r_grant_ls;
    assign estado    = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. The main instance uses READ_LAT=2 and a
// behavioural memory. Two extra instances use READ_LAT=1 and READ_LAT=8, and
// the bench drives their read data only in the cycle it must be captured.
module tb_mem_arbiter;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // main instance, READ_LAT = 2
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_ack, ls_ack, mem_wr, busy, grant_ls;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  estado;

    mem_arbiter #(.READ_LAT(2)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .busy(busy), .grant_ls(grant_ls), .estado(estado)
    );

    // READ_LAT = 1 instance (a_*) and READ_LAT = 8 instance (b_*), fetch port only
    logic        a_if_req, b_if_req;
    logic [31:0] a_if_addr, b_if_addr, a_mem_rdata, b_mem_rdata;
    logic        a_if_ack, a_ls_ack, a_mem_wr, a_busy, a_grant_ls;
    logic        b_if_ack, b_ls_ack, b_mem_wr, b_busy, b_grant_ls;
    logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata;
    logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;
    logic [1:0]  a_estado, b_estado;
    logic        idle_req  = 1'b0;
    logic [31:0] idle_word = 32'd0;

    mem_arbiter #(.READ_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .ls_req(idle_req), .ls_we(idle_req), .ls_addr(idle_word), .ls_wdata(idle_word),
        .ls_ack(a_ls_ack), .ls_rdata(a_ls_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wr(a_mem_wr), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .grant_ls(a_grant_ls), .estado(a_estado)
    );

    mem_arbiter #(.READ_LAT(8)) u_lat8 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .ls_req(idle_req), .ls_we(idle_req), .ls_addr(idle_word), .ls_wdata(idle_word),
        .ls_ack(b_ls_ack), .ls_rdata(b_ls_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wr(b_mem_wr), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .grant_ls(b_grant_ls), .estado(b_estado)
    );

    int total = 0;
    int bad   = 0;

    // Memory model for the main instance. Word 0x10 holds 0xDEADBEEF.
    // Other unwritten words hold {16'hA5A5, addr[15:0]}. Reads have two cycles of latency.
    bit [31:0]   wmem [0:255];
    bit [255:0]  wvalid;
    logic [31:0] r_pipe = JUNK;

    function automatic logic [31:0] read_word(input logic [31:0] a);
        if (wvalid[a[9:2]]) return wmem[a[9:2]];
        if (a == 32'h10)    return 32'hDEAD_BEEF;
        return {16'hA5A5, a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_wr) begin
            wmem[mem_addr[9:2]]   <= mem_wdata;
            wvalid[mem_addr[9:2]] <= 1'b1;
        end
        r_pipe <= read_word(mem_addr);
    end
    assign mem_rdata = r_pipe;

    // Cycle-level monitors, sampled away from the active edge.
    int both_ack_cnt = 0;
    int mem_wr_cnt   = 0;
    int stray_ls_cnt = 0;
    always @(negedge clk) begin
        if (if_ack && ls_ack) both_ack_cnt++;
        if (mem_wr) mem_wr_cnt++;
        if (a_ls_ack || b_ls_ack || a_mem_wr || b_mem_wr) stray_ls_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (estado !== 2'd0) begin bad++; $display("FAIL reset_estado: got %0d want 0", estado); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({if_ack, ls_ack, mem_wr} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b want 000", {if_ack, ls_ack, mem_wr}); end
        total++; if ({mem_addr, mem_wdata} !== 64'd0) begin bad++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
        total++; if ({if_rdata, ls_rdata} !== 64'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, ls_rdata}); end
        total++; if (grant_ls !== 1'b0) begin bad++; $display("FAIL reset_grant_ls: got %b want 0", grant_ls); end
        reset = 1'b1;
    endtask

    task automatic test_fetch(input logic [31:0] addr, input logic [31:0] exp_data);
        int j;
        int wr_before;
        wr_before = mem_wr_cnt;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = addr;
        j = 0;
        while (j < 12) begin
            @(negedge clk);
            j++;
            if (j == 1) begin
                total++; if (estado !== 2'd1 || busy !== 1'b1 || grant_ls !== 1'b0) begin
                    bad++; $display("FAIL fetch_grant: estado=%0d busy=%b grant_ls=%b want 1/1/0", estado, busy, grant_ls);
                end
                total++; if (mem_addr !== addr) begin bad++; $display("FAIL fetch_mem_addr: got %h want %h", mem_addr, addr); end
            end
            if (if_ack) break;
        end
        total++; if (j !== 3) begin bad++; $display("FAIL fetch_latency: ack at cycle %0d want 3", j); end
        total++; if (if_rdata !== exp_data) begin bad++; $display("FAIL fetch_rdata: got %h want %h", if_rdata, exp_data); end
        total++; if (ls_ack !== 1'b0) begin bad++; $display("FAIL fetch_other_ack: ls_ack=%b want 0", ls_ack); end
        @(negedge clk);
        total++; if (if_ack !== 1'b0 || estado !== 2'd0) begin
            bad++; $display("FAIL fetch_ack_pulse: if_ack=%b estado=%0d want 0/0", if_ack, estado);
        end
        if_req = 1'b0;
        total++; if (mem_wr_cnt !== wr_before) begin bad++; $display("FAIL fetch_no_write: mem_wr cycles %0d want 0", mem_wr_cnt - wr_before); end
    endtask

    task automatic test_load_abandon();
        int j;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
        j = 0;
        while (j < 12) begin
            @(negedge clk);
            j++;
            if (j == 1) begin
                ls_req  = 1'b0;           // requester walks away mid-transaction
                if_addr = 32'hFFFF_0000;  // non-owner port wiggles its address
            end
            if (j == 2) if_addr = 32'h0000_FFFC;
            total++; if (mem_addr !== 32'h80) begin bad++; $display("FAIL load_mem_addr: cycle %0d got %h want 00000080", j, mem_addr); end
            if (ls_ack) break;
        end
        total++; if (j !== 3) begin bad++; $display("FAIL load_latency: ack at cycle %0d want 3", j); end
        total++; if (ls_rdata !== 32'hA5A5_0080) begin bad++; $display("FAIL load_rdata: got %h want a5a50080", ls_rdata); end
        total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL load_other_ack: if_ack=%b want 0", if_ack); end
        @(negedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0 || ls_ack !== 1'b0) begin bad++; $display("FAIL load_settle: busy=%b ls_ack=%b want 0/0", busy, ls_ack); end
    endtask

    task automatic test_store();
        int j;
        int wr_before;
        wr_before = mem_wr_cnt;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h1234_5678;
        j = 0;
        while (j < 12) begin
            @(negedge clk);
            j++;
            if (j == 1) begin
                total++; if (mem_wr !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234_5678) begin
                    bad++; $display("FAIL store_bus: wr=%b addr=%h wdata=%h want 1/00000040/12345678", mem_wr, mem_addr, mem_wdata);
                end
            end
            if (ls_ack) break;
        end
        total++; if (j !== 2) begin bad++; $display("FAIL store_latency: ack at cycle %0d want 2", j); end
        total++; if (mem_wr_cnt - wr_before !== 1) begin bad++; $display("FAIL store_wr_cycles: got %0d want 1", mem_wr_cnt - wr_before); end
        total++; if (ls_rdata !== 32'hA5A5_0080) begin bad++; $display("FAIL store_keeps_rdata: got %h want a5a50080", ls_rdata); end
        @(negedge clk);
        ls_req = 1'b0; ls_we = 1'b0;
        total++; if (ls_ack !== 1'b0 || mem_wr !== 1'b0) begin bad++; $display("FAIL store_pulse: ls_ack=%b mem_wr=%b want 0/0", ls_ack, mem_wr); end
    endtask

    task automatic test_round_robin();
        int j;
        int n;
        int seq [4];
        int at [4];
        int both_before;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        both_before = both_ack_cnt;
        if_req = 1'b1; if_addr = 32'h30;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
        j = 0; n = 0;
        while (j < 40 && n < 4) begin
            @(negedge clk);
            j++;
            if (if_ack || ls_ack) begin
                seq[n] = ls_ack ? 1 : 0;
                at[n]  = j;
                n++;
            end
        end
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        total++; if (n !== 4) begin bad++; $display("FAIL rr_count: got %0d acks want 4", n); end
        for (int i = 0; i < n; i++) begin
            total++; if (seq[i] !== (i % 2)) begin bad++; $display("FAIL rr_order: ack %0d owner_ls=%0d want %0d", i, seq[i], i % 2); end
            total++; if (at[i] !== 3 + 4 * i) begin bad++; $display("FAIL rr_timing: ack %0d at cycle %0d want %0d", i, at[i], 3 + 4 * i); end
        end
        total++; if (both_ack_cnt !== both_before) begin bad++; $display("FAIL rr_both_acks: %0d cycles want 0", both_ack_cnt - both_before); end
        total++; if (if_rdata !== 32'hA5A5_0030 || ls_rdata !== 32'hA5A5_0020) begin
            bad++; $display("FAIL rr_rdata: if=%h ls=%h want a5a50030/a5a50020", if_rdata, ls_rdata);
        end
    endtask

    task automatic test_reset_abort();
        int acks;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h50; ls_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL abort_setup: mem_wr=%b want 1", mem_wr); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (mem_wr !== 1'b0 || busy !== 1'b0 || ls_ack !== 1'b0 || if_ack !== 1'b0) begin
            bad++; $display("FAIL abort_state: wr=%b busy=%b ls_ack=%b if_ack=%b want 0/0/0/0", mem_wr, busy, ls_ack, if_ack);
        end
        total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL abort_mem_addr: got %h want 0", mem_addr); end
        reset = 1'b1;
        ls_req = 1'b0; ls_we = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ls_ack || mem_wr) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL abort_no_ack: %0d late ack/write cycles want 0", acks); end
        test_fetch(32'h10, 32'hDEAD_BEEF);
    endtask

    task automatic test_latency(input int lat);
        int j;
        logic ack;
        logic [31:0] rd;
        logic [31:0] word;
        word = (lat == 1) ? 32'h1111_0001 : 32'h8888_0008;
        @(negedge clk);
        if (lat == 1) begin a_if_req = 1'b1; a_if_addr = 32'h100; end
        else          begin b_if_req = 1'b1; b_if_addr = 32'h200; end
        j = 0; ack = 1'b0; rd = '0;
        while (j < 20) begin
            @(negedge clk);
            j++;
            ack = (lat == 1) ? a_if_ack   : b_if_ack;
            rd  = (lat == 1) ? a_if_rdata : b_if_rdata;
            if (ack) break;
            // present valid data only in the cycle the capture edge must see it
            if (lat == 1) a_mem_rdata = (j == lat) ? word : JUNK;
            else          b_mem_rdata = (j == lat) ? word : JUNK;
        end
        total++; if (j !== lat + 1) begin bad++; $display("FAIL lat%0d_timing: ack at cycle %0d want %0d", lat, j, lat + 1); end
        total++; if (rd !== word) begin bad++; $display("FAIL lat%0d_rdata: got %h want %h", lat, rd, word); end
        @(negedge clk);
        ack = (lat == 1) ? a_if_ack : b_if_ack;
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL lat%0d_pulse: ack=%b want 0", lat, ack); end
        a_if_req = 1'b0; b_if_req = 1'b0;
        a_mem_rdata = JUNK; b_mem_rdata = JUNK;
    endtask

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        a_if_req = 1'b0; a_if_addr = '0; a_mem_rdata = JUNK;
        b_if_req = 1'b0; b_if_addr = '0; b_mem_rdata = JUNK;

        test_reset();
        test_fetch(32'h10, 32'hDEAD_BEEF);
        test_load_abandon();
        test_store();
        test_fetch(32'h40, 32'h1234_5678);
        test_round_robin();
        test_reset_abort();
        test_latency(1);
        test_latency(8);

        total++; if (stray_ls_cnt !== 0) begin bad++; $display("FAIL lat_stray: %0d unexpected ls/write cycles want 0", stray_ls_cnt); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
